// File: rtl/m6809_core_pull_if.sv
// Bus/handshake bundle for the 6809 stack-pull sequencer.
//   start/ir_in : instruction launch (pulse + opcode)
//   addr/din    : memory read port (din valid the cycle after addr)
//   data_rw_n   : memory direction, always read
//   bus_oe      : sequencer owns the memory bus
//   busy/done   : instruction in progress / one-cycle completion pulse
// Modport master is the sequencer's view; slave is the core/memory view.
interface m6809_core_pull_if;
  logic        start;
  logic [7:0]  ir_in;
  logic [15:0] addr;
  logic        data_rw_n;
  logic        bus_oe;
  logic [7:0]  din;
  logic        busy;
  logic        done;

  modport master (
    input  start, ir_in, din,
    output addr, data_rw_n, bus_oe, busy, done
  );

  modport slave (
    output start, ir_in, din,
    input  addr, data_rw_n, bus_oe, busy, done
  );
endinterface

// File: rtl/m6809_core_pull.sv
// 6809 PULS/PULU sequencer. Fetches the post-byte at PC, then reads the
// selected registers off the S or U stack (lowest post-byte bit first),
// one byte per ADDR/DATA cycle pair, and finally writes back the pointer.
// Ports:
//   clk, reg_reset        : clock, async active-high reset
//   bus                   : start/ir_in launch, memory read port, busy/done
//   pc_in, s_in, u_in     : current PC/S/U, latched at start
//   *_out / *_out_en      : restored register values + one-cycle strobes
module m6809_core_pull (
  input  logic                     clk,
  input  logic                     reg_reset,
  m6809_core_pull_if.master        bus,
  input  logic [15:0]              pc_in,
  input  logic [15:0]              s_in,
  input  logic [15:0]              u_in,
  output logic [7:0]               a_out,
  output logic [7:0]               b_out,
  output logic [7:0]               ccr_out,
  output logic [7:0]               dpr_out,
  output logic [15:0]              x_out,
  output logic [15:0]              y_out,
  output logic [15:0]              s_out,
  output logic [15:0]              u_out,
  output logic [15:0]              pc_out,
  output logic                     a_out_en,
  output logic                     b_out_en,
  output logic                     ccr_out_en,
  output logic                     dpr_out_en,
  output logic                     x_out_en,
  output logic                     y_out_en,
  output logic                     s_out_en,
  output logic                     u_out_en,
  output logic                     pc_out_en
);

  typedef enum logic [2:0] {
    IDLE,
    PB_ADDR,
    PB_DATA,
    BYTE_ADDR,
    BYTE_DATA,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        pull_u;     // 1: PULU (U stack), 0: PULS (S stack)
  logic [15:0] pc_w;
  logic [15:0] sp_w;
  logic [7:0]  mask;       // post-byte bits still to be pulled
  logic        lo_phase;   // current 16-bit item is on its lo byte
  logic [7:0]  hi_byte;

  logic        accept;
  logic [2:0]  item;       // lowest pending post-byte bit
  logic        item_wide;
  logic        byte_last;  // this byte completes the current item
  logic [7:0]  mask_clr;

  assign accept = (state == IDLE) && bus.start &&
                  ((bus.ir_in == 8'h35) || (bus.ir_in == 8'h37));

  // Priority encode from the top down so the lowest set bit wins.
  always_comb begin
    item = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (mask[i-1]) item = 3'(i - 1);
    end
  end

  // Bits 4..7 (X, Y, other SP, PC) are 16-bit items.
  assign item_wide = item[2];
  assign byte_last = !item_wide || lo_phase;
  assign mask_clr  = mask & ~(8'b1 << item);

  // State register
  always_ff @(posedge clk or posedge reg_reset) begin
    if (reg_reset) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (accept) state_nxt = PB_ADDR;
      PB_ADDR:   state_nxt = PB_DATA;
      PB_DATA:   state_nxt = (bus.din == 8'h00) ? DONE : BYTE_ADDR;
      BYTE_ADDR: state_nxt = BYTE_DATA;
      BYTE_DATA: state_nxt = (byte_last && (mask_clr == 8'h00)) ? DONE
                                                                : BYTE_ADDR;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reg_reset) begin
    if (reg_reset) begin
      pull_u   <= 1'b0;
      pc_w     <= '0;
      sp_w     <= '0;
      mask     <= '0;
      lo_phase <= 1'b0;
      hi_byte  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            pull_u   <= bus.ir_in[1];
            pc_w     <= pc_in;
            sp_w     <= bus.ir_in[1] ? u_in : s_in;
            lo_phase <= 1'b0;
          end
        end
        PB_DATA: mask <= bus.din;
        BYTE_DATA: begin
          sp_w <= sp_w + 16'd1;
          if (byte_last) begin
            mask     <= mask_clr;
            lo_phase <= 1'b0;
          end else begin
            hi_byte  <= bus.din;
            lo_phase <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.data_rw_n = 1'b1;

  // Output logic
  always_comb begin
    bus.addr   = '0;
    bus.bus_oe = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    a_out      = '0;
    b_out      = '0;
    ccr_out    = '0;
    dpr_out    = '0;
    x_out      = '0;
    y_out      = '0;
    s_out      = '0;
    u_out      = '0;
    pc_out     = '0;
    a_out_en   = 1'b0;
    b_out_en   = 1'b0;
    ccr_out_en = 1'b0;
    dpr_out_en = 1'b0;
    x_out_en   = 1'b0;
    y_out_en   = 1'b0;
    s_out_en   = 1'b0;
    u_out_en   = 1'b0;
    pc_out_en  = 1'b0;

    if (state != IDLE) begin
      bus.bus_oe = 1'b1;
      bus.busy   = 1'b1;
    end

    unique case (state)
      PB_ADDR: bus.addr = pc_w;
      PB_DATA: begin
        bus.addr  = pc_w;
        pc_out    = pc_w + 16'd1;
        pc_out_en = 1'b1;
      end
      BYTE_ADDR: bus.addr = sp_w;
      BYTE_DATA: begin
        bus.addr = sp_w;
        unique case (item)
          3'd0: begin ccr_out = bus.din; ccr_out_en = 1'b1; end
          3'd1: begin a_out   = bus.din; a_out_en   = 1'b1; end
          3'd2: begin b_out   = bus.din; b_out_en   = 1'b1; end
          3'd3: begin dpr_out = bus.din; dpr_out_en = 1'b1; end
          3'd4: if (lo_phase) begin x_out = {hi_byte, bus.din}; x_out_en = 1'b1; end
          3'd5: if (lo_phase) begin y_out = {hi_byte, bus.din}; y_out_en = 1'b1; end
          3'd6: begin
            // Bit 6 is the stack not being pulled from.
            if (lo_phase) begin
              if (pull_u) begin s_out = {hi_byte, bus.din}; s_out_en = 1'b1; end
              else        begin u_out = {hi_byte, bus.din}; u_out_en = 1'b1; end
            end
          end
          3'd7: if (lo_phase) begin pc_out = {hi_byte, bus.din}; pc_out_en = 1'b1; end
          default: ;
        endcase
      end
      DONE: begin
        bus.done = 1'b1;
        if (pull_u) begin u_out = sp_w; u_out_en = 1'b1; end
        else        begin s_out = sp_w; s_out_en = 1'b1; end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_m6809_core_pull.sv
module tb_m6809_core_pull;
  logic        clk = 1'b0;
  logic        reg_reset;
  logic [15:0] pc_in, s_in, u_in;
  logic [7:0]  a_out, b_out, ccr_out, dpr_out;
  logic [15:0] x_out, y_out, s_out, u_out, pc_out;
  logic        a_out_en, b_out_en, ccr_out_en, dpr_out_en;
  logic        x_out_en, y_out_en, s_out_en, u_out_en, pc_out_en;

  m6809_core_pull_if bus();

  m6809_core_pull dut (
    .clk(clk), .reg_reset(reg_reset), .bus(bus),
    .pc_in(pc_in), .s_in(s_in), .u_in(u_in),
    .a_out(a_out), .b_out(b_out), .ccr_out(ccr_out), .dpr_out(dpr_out),
    .x_out(x_out), .y_out(y_out), .s_out(s_out), .u_out(u_out), .pc_out(pc_out),
    .a_out_en(a_out_en), .b_out_en(b_out_en), .ccr_out_en(ccr_out_en),
    .dpr_out_en(dpr_out_en), .x_out_en(x_out_en), .y_out_en(y_out_en),
    .s_out_en(s_out_en), .u_out_en(u_out_en), .pc_out_en(pc_out_en)
  );

  always #5 clk = ~clk;

  // Memory with a one-cycle read latency.
  logic [7:0] mem [0:65535];
  always @(posedge clk) bus.din <= mem[bus.addr];

  int vectors = 0;
  int miscompares = 0;

  // Expected per-cycle behaviour. Register index: 0 CC,1 A,2 B,3 DP,4 X,5 Y,6 S,7 U,8 PC.
  logic [15:0] e_addr [0:31];
  logic        e_achk [0:31];
  logic        e_busy [0:31];
  logic        e_done [0:31];
  logic [8:0]  e_en   [0:31];
  logic [15:0] e_val  [0:31][0:8];
  int          last;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] obs_en();
    return {pc_out_en, u_out_en, s_out_en, y_out_en, x_out_en,
            dpr_out_en, b_out_en, a_out_en, ccr_out_en};
  endfunction

  function automatic logic [111:0] obs_val();
    return {pc_out, u_out, s_out, y_out, x_out, dpr_out, b_out, a_out, ccr_out};
  endfunction

  function automatic logic [111:0] exp_val(input int c);
    return {e_val[c][8], e_val[c][7], e_val[c][6], e_val[c][5], e_val[c][4],
            e_val[c][3][7:0], e_val[c][2][7:0], e_val[c][1][7:0], e_val[c][0][7:0]};
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, " en"},     128'(obs_en()), 128'(0));
    chk({tag, " data"},   128'(obs_val()), 128'(0));
    chk({tag, " status"}, 128'({bus.busy, bus.bus_oe, bus.done, bus.data_rw_n}), 128'(4'b0001));
    chk({tag, " addr"},   128'(bus.addr), 128'(0));
  endtask

  task automatic check_cycle(input string name, input int c);
    string t;
    t = $sformatf("%s c%0d", name, c);
    chk({t, " en"},     128'(obs_en()), 128'(e_en[c]));
    chk({t, " data"},   128'(obs_val()), 128'(exp_val(c)));
    chk({t, " status"}, 128'({bus.busy, bus.bus_oe, bus.done, bus.data_rw_n}),
                        128'({e_busy[c], e_busy[c], e_done[c], 1'b1}));
    if (e_achk[c]) chk({t, " addr"}, 128'(bus.addr), 128'(e_addr[c]));
  endtask

  // Reference model: walk the post-byte bits and lay the expected events out on a timeline.
  task automatic build(input bit pu, input logic [7:0] pb, input logic [15:0] pc, input logic [15:0] sp);
    int c;
    int r;
    logic [15:0] p;
    logic [7:0] hi;
    for (int i = 0; i < 32; i++) begin
      e_addr[i] = '0; e_achk[i] = 1'b1; e_busy[i] = 1'b0; e_done[i] = 1'b0; e_en[i] = '0;
      for (int k = 0; k < 9; k++) e_val[i][k] = '0;
    end
    e_busy[1] = 1'b1; e_addr[1] = pc;
    e_busy[2] = 1'b1; e_addr[2] = pc; e_en[2][8] = 1'b1; e_val[2][8] = pc + 16'd1;
    c = 3; p = sp; hi = '0;
    for (int b = 0; b < 8; b++) begin
      if (pb[b]) begin
        r = (b < 6) ? b : (b == 6) ? (pu ? 6 : 7) : 8;
        if (b < 4) begin
          e_busy[c] = 1'b1; e_addr[c] = p;
          e_busy[c+1] = 1'b1; e_addr[c+1] = p;
          e_en[c+1][r] = 1'b1; e_val[c+1][r] = {8'h00, mem[p]};
          p = p + 16'd1; c += 2;
        end else begin
          hi = mem[p];
          e_busy[c] = 1'b1; e_addr[c] = p;
          e_busy[c+1] = 1'b1; e_addr[c+1] = p;
          p = p + 16'd1; c += 2;
          e_busy[c] = 1'b1; e_addr[c] = p;
          e_busy[c+1] = 1'b1; e_addr[c+1] = p;
          e_en[c+1][r] = 1'b1; e_val[c+1][r] = {hi, mem[p]};
          p = p + 16'd1; c += 2;
        end
      end
    end
    e_busy[c] = 1'b1; e_done[c] = 1'b1; e_achk[c] = 1'b0;
    e_en[c][pu ? 7 : 6] = 1'b1; e_val[c][pu ? 7 : 6] = p;
    last = c;
  endtask

  // Runs one instruction from a negedge; abort_at >= 0 asserts reset in that cycle.
  task automatic run_txn(input string name, input bit pu, input logic [7:0] pb,
                         input logic [15:0] pc, input logic [15:0] sp,
                         input int abort_at, input bit noise);
    mem[pc] = pb;
    build(pu, pb, pc, sp);
    bus.ir_in = pu ? 8'h37 : 8'h35;
    bus.start = 1'b1;
    pc_in = pc;
    s_in = pu ? 16'($urandom) : sp;
    u_in = pu ? sp : 16'($urandom);
    check_cycle(name, 0);
    for (int c = 1; c <= last + 1; c++) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      if (noise) begin
        pc_in = 16'($urandom); s_in = 16'($urandom); u_in = 16'($urandom);
        if (c <= last && ($urandom_range(3) == 0)) begin
          bus.start = 1'b1;
          bus.ir_in = ($urandom_range(1) == 1) ? 8'h37 : 8'h35;
        end
      end
      if (c == abort_at) begin
        reg_reset = 1'b1;
        #1;
        check_idle($sformatf("%s reset c%0d", name, c));
        @(negedge clk);
        reg_reset = 1'b0;
        return;
      end
      check_cycle(name, c);
    end
  endtask

  initial begin
    bit pu;
    logic [7:0] pb;
    logic [15:0] pc, sp;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    reg_reset = 1'b1;
    bus.start = 1'b0;
    bus.ir_in = 8'h00;
    pc_in = '0; s_in = '0; u_in = '0;
    #1;
    check_idle("reset");
    @(negedge clk);
    @(negedge clk);
    reg_reset = 1'b0;
    @(negedge clk);

    // PULS A,B
    mem[16'h0010] = 8'h41; mem[16'h0011] = 8'h42;
    run_txn("puls_ab", 1'b0, 8'h06, 16'h1234, 16'h0010, -1, 1'b0);

    // PULS all, with memory 0x10+i from 0
    for (int i = 0; i < 12; i++) mem[i] = 8'(8'h10 + i);
    run_txn("puls_all", 1'b0, 8'hFF, 16'h2000, 16'h0000, -1, 1'b0);

    // PULU S
    mem[16'h0080] = 8'h12; mem[16'h0081] = 8'h34;
    run_txn("pulu_s", 1'b1, 8'h40, 16'h3000, 16'h0080, -1, 1'b0);

    // Empty post-byte
    run_txn("empty", 1'b0, 8'h00, 16'h4000, 16'h0055, -1, 1'b0);

    // Stack pointer wrap
    mem[16'hFFFF] = 8'h99;
    run_txn("wrap", 1'b0, 8'h02, 16'h5000, 16'hFFFF, -1, 1'b0);

    // PC wrap on post-byte fetch
    run_txn("pcwrap", 1'b1, 8'h81, 16'hFFFF, 16'h0100, -1, 1'b0);

    // Non-pull opcode is ignored
    bus.ir_in = 8'h34;
    bus.start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      check_idle($sformatf("bad_op c%0d", c));
    end

    // Reset mid-instruction, then a normal instruction
    for (int i = 0; i < 12; i++) mem[i] = 8'(8'h10 + i);
    run_txn("abort", 1'b0, 8'hFF, 16'h2000, 16'h0000, 5, 1'b0);
    check_idle("post_abort");
    mem[16'h0010] = 8'h41; mem[16'h0011] = 8'h42;
    run_txn("after_abort", 1'b0, 8'h06, 16'h1234, 16'h0010, -1, 1'b0);

    // Random instructions with input noise and start pulses while busy
    for (int n = 0; n < 40; n++) begin
      pu = 1'($urandom);
      pb = 8'($urandom);
      pc = 16'($urandom);
      sp = 16'($urandom);
      run_txn($sformatf("rnd%0d", n), pu, pb, pc, sp, -1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/m6809_core_pull.md
Name: m6809_core_pull

Overview:
- Executes the 6809 stack-pull instructions PULS (0x35) and PULU (0x37).
- It is the read-side counterpart of the core's push sequencer.
- It fetches the post-byte, then reads the selected registers off the S or U stack through the external memory port, incrementing the stack pointer after each byte.
- It presents each restored register value plus a one-cycle write enable to the core register file, then writes back the updated stack pointer.

Parameters:
- None.

Ports:
- clk  in  1  system clock, all state on rising edge
- reg_reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begin instruction in ir_in
- ir_in  in  8  opcode; 0x35 = PULS, 0x37 = PULU
- addr  out  16  memory address
- data_rw_n  out  1  memory direction; constant 1 (read)
- bus_oe  out  1  block owns the memory bus
- din  in  8  memory read data; valid the cycle after addr is driven
- pc_in, s_in, u_in  in  16 each  current PC/S/U
- a_out, b_out, ccr_out, dpr_out  out  8 each  restored 8-bit values
- x_out, y_out, s_out, u_out, pc_out  out  16 each  restored or updated 16-bit values
- a_out_en, b_out_en, ccr_out_en, dpr_out_en, x_out_en, y_out_en, s_out_en, u_out_en, pc_out_en  out  1 each  one-cycle write strobes
- busy  out  1  instruction in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Cycle numbering: cycle 0 is the cycle in which start=1 is sampled.
- start is accepted only in IDLE with ir_in ∈ {0x35, 0x37}. Otherwise it is ignored: no bus activity, no strobes.
- On acceptance, latch the following:
  - the pull stack: PULS → S, PULU → U;
  - pc_in into pc_w;
  - the selected pointer into sp_w (16 bits).
- States:
  - IDLE
  - PB_ADDR: addr=pc_w.
  - PB_DATA: post-byte = din; pc_out=pc_w+1, pc_out_en=1.
  - BYTE_ADDR: addr=sp_w.
  - BYTE_DATA: capture din; sp_w ← sp_w+1.
  - DONE: pointer write-back, done=1; then IDLE.
- bus_oe=1 and busy=1 in every state except IDLE.
- addr is held stable across each ADDR/DATA pair. addr=0 in IDLE.
- Pull order (lowest post-byte bit first):
  - bit0 CC
  - bit1 A
  - bit2 B
  - bit3 DP
  - bit4 X hi, lo
  - bit5 Y hi, lo
  - bit6 other stack pointer hi, lo (U for PULS, S for PULU)
  - bit7 PC hi, lo
- Clear bits are skipped with zero cycles.
- Each byte costs exactly two cycles (ADDR, DATA).
- 8-bit registers: *_out=din and *_out_en=1 combinationally during that BYTE_DATA cycle.
- 16-bit registers: the hi byte is held internally; in the lo-byte BYTE_DATA cycle, *_out={hi,din} and *_out_en=1.
- DONE: the pull stack pointer output is sp_w, with its enable asserted.
- Latency: done occurs in cycle 3+2N, where N is the byte count (0..12).
- Post-byte 0x00 → DONE at cycle 3; pointer written back unchanged.
- Pulled PC (bit7) strobes pc_out_en again with the pulled value, overriding the earlier +1 update. At most one pc_out_en per cycle.
- PULU pulling S: s_out_en fires at the S lo byte; u_out_en fires at DONE. Never two writes to one register in one cycle.
- 16-bit wrap: sp_w 0xFFFF+1 = 0x0000, and pc_w 0xFFFF+1 = 0x0000. No flags.
- start while busy is ignored.
- Inputs pc_in/s_in/u_in are ignored after cycle 0; only latched copies are used.
- Reset / idle values:
  - All *_out_en, done, busy, bus_oe = 0.
  - All data outputs and addr = 0.
  - data_rw_n = 1.
- reg_reset mid-operation: immediate return to IDLE with the reset values above. No partial pointer write-back. The next valid start runs normally.
- Every strobe is a single-cycle pulse. All outputs not enabled read 0.

Test Plan:
- PULS, pc=0x1234, mem[0x1234]=0x06, s=0x0010, mem[0x10]=0x41, mem[0x11]=0x42 → pc_out=0x1235 en at cycle 2; a_out=0x41 at cycle 4; b_out=0x42 at cycle 6; s_out=0x0012 and done at cycle 7.
- PULS post-byte 0xFF, s=0x0000, mem[i]=0x10+i → CC=0x10, A=0x11, B=0x12, DP=0x13, X=0x1415, Y=0x1617, U=0x1819, PC=0x1A1B (pc_out_en at cycles 2 and 26); s_out=0x000C; done at cycle 27.
- PULU post-byte 0x40, u=0x0080, mem[0x80]=0x12, mem[0x81]=0x34 → s_out=0x1234 en at cycle 6; u_out=0x0082 en at cycle 7; no other strobes.
- Post-byte 0x00, s=0x0055 → done at cycle 3, s_out=0x0055; no BYTE states entered.
- Wrap case: PULS post-byte 0x02, s=0xFFFF, mem[0xFFFF]=0x99 → addr=0xFFFF in cycles 3-4; a_out=0x99; s_out=0x0000.
- Edge cases:
  - start with ir_in=0x34 → busy stays 0.
  - start during busy → ignored.
  - reg_reset at cycle 5 of the 0xFF case → all strobes 0 and busy 0 immediately; a following PULS completes correctly.
